// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/LSU memory arbiter: FSM state codes,
// requester ids and the byte-lane merge used by partial-word stores.
package mem_arb_pkg;

    localparam int STATE_W = 1;

    localparam logic [STATE_W-1:0] ST_IDLE   = 1'b0;
    localparam logic [STATE_W-1:0] ST_RMW_WR = 1'b1;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_FULL = 4'b1111;

    // Enabled lanes come from the store data, all others keep the old memory word.
    function automatic logic [31:0] laneMerge(
        input logic [3:0]  be,
        input logic [31:0] wdata,
        input logic [31:0] rdata
    );
        logic [31:0] merged;
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational byte-lane merge for the read-modify-write store path.
module mem_lane_merge
    import mem_arb_pkg::*;
(
    input  logic [3:0]  i_be,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_merged
);

    assign o_merged = laneMerge(i_be, i_wdata, i_rdata);

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Single-port memory arbiter between instruction fetch (port 0) and the LSU
// (port 1): data-port priority with starvation relief, RMW for partial stores.
module mem_arbiter_ctrl
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        mem_read_control,
    output logic        mem_write_control,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_starveCnt;
    logic               r_m0Rvalid;
    logic [31:0]        r_m0Rdata;
    logic               r_m1Rvalid;
    logic [31:0]        r_m1Rdata;
    logic [31:0]        r_rmwAddr;
    logic [31:0]        r_rmwData;

    logic        w_arbitrate;
    logic        w_starved;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_m1Load;
    logic        w_m1FullStore;
    logic        w_m1EmptyStore;
    logic        w_m1PartStore;
    logic        w_rmwWrite;
    logic        w_m1Ack;
    logic [31:0] w_merged;

    // Reset gates every grant and memory strobe so nothing reaches memory while held.
    assign w_arbitrate = !reset && (r_state == ST_IDLE);
    assign w_rmwWrite  = !reset && (r_state == ST_RMW_WR);
    assign w_starved   = (r_starveCnt >= STARVE_MAX);

    assign w_gnt0 = w_arbitrate && m0_req && (!m1_req || w_starved);
    assign w_gnt1 = w_arbitrate && m1_req && !w_gnt0;

    assign w_m1Load       = w_gnt1 && !m1_we;
    assign w_m1FullStore  = w_gnt1 && m1_we && (m1_be == BE_FULL);
    assign w_m1EmptyStore = w_gnt1 && m1_we && (m1_be == BE_NONE);
    assign w_m1PartStore  = w_gnt1 && m1_we && (m1_be != BE_FULL) && (m1_be != BE_NONE);

    assign w_m1Ack = w_m1Load || w_m1FullStore || w_m1EmptyStore || w_rmwWrite;

    mem_lane_merge u_laneMerge (
        .i_be     (m1_be),
        .i_wdata  (m1_wdata),
        .i_rdata  (mem_rdata),
        .o_merged (w_merged)
    );

    always_comb begin
        mem_read_control  = 1'b0;
        mem_write_control = 1'b0;
        mem_addr          = 32'h0;
        mem_wdata         = 32'h0;
        if (w_gnt0) begin
            mem_read_control = 1'b1;
            mem_addr         = m0_addr;
        end else if (w_m1Load || w_m1PartStore) begin
            mem_read_control = 1'b1;
            mem_addr         = m1_addr;
        end else if (w_m1FullStore) begin
            mem_write_control = 1'b1;
            mem_addr          = m1_addr;
            mem_wdata         = m1_wdata;
        end else if (w_rmwWrite) begin
            mem_write_control = 1'b1;
            mem_addr          = r_rmwAddr;
            mem_wdata         = r_rmwData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_starveCnt <= '0;
            r_m0Rvalid  <= 1'b0;
            r_m0Rdata   <= 32'h0;
            r_m1Rvalid  <= 1'b0;
            r_m1Rdata   <= 32'h0;
            r_rmwAddr   <= 32'h0;
            r_rmwData   <= 32'h0;
        end else begin
            if (w_m1PartStore) begin
                r_state   <= ST_RMW_WR;
                r_rmwAddr <= m1_addr;
                r_rmwData <= w_merged;
            end else if (r_state == ST_RMW_WR) begin
                r_state <= ST_IDLE;
            end

            // Counts cycles fetch waits while requesting; RMW_WR cycles count too.
            if (!m0_req || w_gnt0) begin
                r_starveCnt <= '0;
            end else if (!w_starved) begin
                r_starveCnt <= r_starveCnt + 1'b1;
            end

            r_m0Rvalid <= w_gnt0;
            if (w_gnt0) begin
                r_m0Rdata <= mem_rdata;
            end

            r_m1Rvalid <= w_m1Ack;
            if (w_m1Ack) begin
                r_m1Rdata <= w_m1Load ? mem_rdata : 32'h0;
            end
        end
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_m0Rvalid;
    assign m0_rdata  = r_m0Rdata;
    assign m1_rvalid = r_m1Rvalid;
    assign m1_rdata  = r_m1Rdata;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a behavioural word memory attached.
module tb_mem_arbiter_ctrl;

    logic        clk;
    logic        reset;
    logic        m0Req;
    logic [31:0] m0Addr;
    logic        m0Gnt;
    logic        m0Rvalid;
    logic [31:0] m0Rdata;
    logic        m1Req;
    logic        m1We;
    logic [3:0]  m1Be;
    logic [31:0] m1Addr;
    logic [31:0] m1Wdata;
    logic        m1Gnt;
    logic        m1Rvalid;
    logic [31:0] m1Rdata;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;

    logic [31:0] memArr [0:63];
    logic        memLoad;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        m0Req;
        logic [31:0] m0Addr;
        logic        m1Req;
        logic        m1We;
        logic [3:0]  m1Be;
        logic [31:0] m1Addr;
        logic [31:0] m1Wdata;
        logic        expGnt0;
        logic        expGnt1;
        logic        expRd;
        logic        expWr;
        logic        expRv0;
        logic [31:0] expData0;
        logic        expRv1;
        logic [31:0] expData1;
    } vec_t;

    vec_t vecs [6];

    mem_arbiter_ctrl #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk               (clk),
        .reset             (reset),
        .m0_req            (m0Req),
        .m0_addr           (m0Addr),
        .m0_gnt            (m0Gnt),
        .m0_rvalid         (m0Rvalid),
        .m0_rdata          (m0Rdata),
        .m1_req            (m1Req),
        .m1_we             (m1We),
        .m1_be             (m1Be),
        .m1_addr           (m1Addr),
        .m1_wdata          (m1Wdata),
        .m1_gnt            (m1Gnt),
        .m1_rvalid         (m1Rvalid),
        .m1_rdata          (m1Rdata),
        .mem_read_control  (memRead),
        .mem_write_control (memWrite),
        .mem_addr          (memAddr),
        .mem_wdata         (memWdata),
        .mem_rdata         (memRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, clocked write, preload on request.
    assign memRdata = memArr[memAddr[7:2]];

    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 64; i++) memArr[i] <= 32'h1000_0000 + 32'(i);
            memArr[3] <= 32'hDEAD_BEEF;
            memArr[4] <= 32'h1122_3344;
        end else if (memWrite) begin
            memArr[memAddr[7:2]] <= memWdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        m0Req   = 1'b0;
        m0Addr  = 32'h0;
        m1Req   = 1'b0;
        m1We    = 1'b0;
        m1Be    = 4'h0;
        m1Addr  = 32'h0;
        m1Wdata = 32'h0;
    endtask

    task automatic applyStimulus(input vec_t v);
        m0Req   = v.m0Req;
        m0Addr  = v.m0Addr;
        m1Req   = v.m1Req;
        m1We    = v.m1We;
        m1Be    = v.m1Be;
        m1Addr  = v.m1Addr;
        m1Wdata = v.m1Wdata;
    endtask

    initial begin
        logic expM1Seq [6];

        clearInputs();
        reset   = 1'b1;
        memLoad = 1'b1;
        stepCycle();
        memLoad = 1'b0;

        // Requests during reset must not be granted.
        m1Req = 1'b1;
        #3;
        checkOutput("rst_gnt1", 32'(m1Gnt), 32'h0);
        checkOutput("rst_rd", 32'(memRead), 32'h0);
        stepCycle();
        reset = 1'b0;
        clearInputs();
        checkOutput("rst_rv0", 32'(m0Rvalid), 32'h0);
        checkOutput("rst_rv1", 32'(m1Rvalid), 32'h0);
        checkOutput("rst_rdata1", m1Rdata, 32'h0);
        stepCycle();

        vecs[0] = '{"load_0c", 0, 32'h0, 1, 0, 4'h0, 32'h0C, 32'h0,
                    0, 1, 1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF};
        vecs[1] = '{"fetch_04", 1, 32'h04, 0, 0, 4'h0, 32'h0, 32'h0,
                    1, 0, 1, 0, 1, 32'h1000_0001, 0, 32'h0};
        vecs[2] = '{"both_m1wins", 1, 32'h08, 1, 0, 4'h0, 32'h14, 32'h0,
                    0, 1, 1, 0, 0, 32'h0, 1, 32'h1000_0005};
        vecs[3] = '{"store_full", 0, 32'h0, 1, 1, 4'hF, 32'h20, 32'hCAFE_F00D,
                    0, 1, 0, 1, 0, 32'h0, 1, 32'h0};
        vecs[4] = '{"store_be0", 0, 32'h0, 1, 1, 4'h0, 32'h24, 32'h5555_5555,
                    0, 1, 0, 0, 0, 32'h0, 1, 32'h0};
        vecs[5] = '{"no_req", 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0,
                    0, 0, 0, 0, 0, 32'h0, 0, 32'h0};

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput({vecs[i].name, "_gnt0"}, 32'(m0Gnt), 32'(vecs[i].expGnt0));
            checkOutput({vecs[i].name, "_gnt1"}, 32'(m1Gnt), 32'(vecs[i].expGnt1));
            checkOutput({vecs[i].name, "_rd"}, 32'(memRead), 32'(vecs[i].expRd));
            checkOutput({vecs[i].name, "_wr"}, 32'(memWrite), 32'(vecs[i].expWr));
            stepCycle();
            clearInputs();
            checkOutput({vecs[i].name, "_rv0"}, 32'(m0Rvalid), 32'(vecs[i].expRv0));
            checkOutput({vecs[i].name, "_rv1"}, 32'(m1Rvalid), 32'(vecs[i].expRv1));
            if (vecs[i].expRv0) checkOutput({vecs[i].name, "_data0"}, m0Rdata, vecs[i].expData0);
            if (vecs[i].expRv1) checkOutput({vecs[i].name, "_data1"}, m1Rdata, vecs[i].expData1);
            stepCycle();
        end
        checkOutput("store_full_mem8", memArr[8], 32'hCAFE_F00D);
        checkOutput("store_be0_mem9", memArr[9], 32'h1000_0009);

        // Starvation: both held, LSU wins four times, fetch wins the fifth, then LSU again.
        expM1Seq = '{1, 1, 1, 1, 0, 1};
        m0Req  = 1'b1;
        m0Addr = 32'h0;
        m1Req  = 1'b1;
        m1Addr = 32'h18;
        for (int i = 0; i < 6; i++) begin
            #3;
            checkOutput($sformatf("starve_gnt1_%0d", i), 32'(m1Gnt), 32'(expM1Seq[i]));
            checkOutput($sformatf("starve_gnt0_%0d", i), 32'(m0Gnt), 32'(!expM1Seq[i]));
            stepCycle();
            if (i == 5) clearInputs();
            checkOutput($sformatf("starve_rv0_%0d", i), 32'(m0Rvalid), 32'(!expM1Seq[i]));
            if (!expM1Seq[i]) checkOutput("starve_data0", m0Rdata, 32'h1000_0000);
            else checkOutput($sformatf("starve_data1_%0d", i), m1Rdata, 32'h1000_0006);
        end
        stepCycle();

        // Partial store: read cycle, write cycle with merged word, ack in the third cycle.
        m1Req   = 1'b1;
        m1We    = 1'b1;
        m1Be    = 4'b0010;
        m1Addr  = 32'h10;
        m1Wdata = 32'h0000_AB00;
        #3;
        checkOutput("rmw_gnt1", 32'(m1Gnt), 32'h1);
        checkOutput("rmw_rd", 32'(memRead), 32'h1);
        checkOutput("rmw_rd_wr", 32'(memWrite), 32'h0);
        stepCycle();
        clearInputs();
        m0Req  = 1'b1;
        m0Addr = 32'h08;
        #3;
        checkOutput("rmw_wr", 32'(memWrite), 32'h1);
        checkOutput("rmw_wr_addr", memAddr, 32'h10);
        checkOutput("rmw_wr_data", memWdata, 32'h1122_AB44);
        checkOutput("rmw_gnt0_blocked", 32'(m0Gnt), 32'h0);
        checkOutput("rmw_early_ack", 32'(m1Rvalid), 32'h0);
        stepCycle();
        checkOutput("rmw_ack", 32'(m1Rvalid), 32'h1);
        checkOutput("rmw_ack_data", m1Rdata, 32'h0);
        checkOutput("rmw_mem4", memArr[4], 32'h1122_AB44);
        #3;
        checkOutput("rmw_gnt0_after", 32'(m0Gnt), 32'h1);
        stepCycle();
        clearInputs();
        checkOutput("rmw_fetch_data", m0Rdata, 32'h1000_0002);
        stepCycle();

        // Reset landing in the RMW write cycle cancels the write and the ack.
        m1Req   = 1'b1;
        m1We    = 1'b1;
        m1Be    = 4'b0001;
        m1Addr  = 32'h14;
        m1Wdata = 32'h0000_00FF;
        #3;
        checkOutput("rstrmw_gnt1", 32'(m1Gnt), 32'h1);
        stepCycle();
        clearInputs();
        reset = 1'b1;
        #3;
        checkOutput("rstrmw_wr", 32'(memWrite), 32'h0);
        stepCycle();
        reset = 1'b0;
        checkOutput("rstrmw_rv1", 32'(m1Rvalid), 32'h0);
        checkOutput("rstrmw_data0", m0Rdata, 32'h0);
        checkOutput("rstrmw_addr", memAddr, 32'h0);
        checkOutput("rstrmw_mem5", memArr[5], 32'h1000_0005);
        #3;
        checkOutput("rstrmw_idle_wr", 32'(memWrite), 32'h0);
        stepCycle();

        // Back-to-back fetches with request held.
        m0Req  = 1'b1;
        m0Addr = 32'h0;
        #3;
        checkOutput("b2b_gnt_a", 32'(m0Gnt), 32'h1);
        stepCycle();
        m0Addr = 32'h4;
        checkOutput("b2b_rv_a", 32'(m0Rvalid), 32'h1);
        checkOutput("b2b_data_a", m0Rdata, 32'h1000_0000);
        #3;
        checkOutput("b2b_gnt_b", 32'(m0Gnt), 32'h1);
        stepCycle();
        clearInputs();
        checkOutput("b2b_rv_b", 32'(m0Rvalid), 32'h1);
        checkOutput("b2b_data_b", m0Rdata, 32'h1000_0001);
        stepCycle();
        checkOutput("b2b_rv_end", 32'(m0Rvalid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
